pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 102 ++++++++++
 tb/tb_pipe_stage_skid.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer, flush-to-bubble and a saturating flush-drop counter.
module pipe_stage_skid #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, emit, load_main, main_from_skid, load_skid;
    logic [1:0]        drop;
    logic [CNT_W:0]    cnt_sum;

    // in_ready comes from registered state only, so out_ready never reaches it combinationally
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign occupancy = state;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready & ~stall;
    assign drop      = occupancy - {1'b0, emit} + {1'b0, accept};
    assign cnt_sum   = {1'b0, flush_cnt} + (CNT_W+1)'(drop);

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        load_main = 1'b1;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_nxt      = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_data <= main_from_skid ? skid_data : in_data;
                main_ctrl <= main_from_skid ? skid_ctrl : in_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
            // a carry into the top bit means the sum passed the maximum, so pin at all-ones
            if (flush) flush_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: vector table for the handshake/skid/flush behaviour plus directed sequences for counter saturation and async reset.
module tb_pipe_stage_skid;
    localparam logic [15:0] B = 16'hBEEF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_data = '0, out_data;
    logic [15:0] in_ctrl = '0, out_ctrl;
    logic        stall = 1'b0, flush = 1'b0;
    logic [1:0]  occupancy, flush_cnt;
    int          n_chk = 0, n_fail = 0;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .CTRL_BUBBLE(B), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .stall(stall), .flush(flush),
        .occupancy(occupancy), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic [31:0] d; logic [15:0] c; logic ordy, stl, fl;
        logic ev; logic [31:0] ed; logic [15:0] ec; logic [1:0] eocc; logic eir; logic [1:0] ecnt;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic [15:0] c,
                         input logic ordy, input logic stl, input logic fl);
        in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; stall = stl; flush = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs = '{
            '{1'b1, 32'h00400004, 16'h0001, 1'b1, 1'b0, 1'b0,  1'b1, 32'h00400004, 16'h0001, 2'd1, 1'b1, 2'd0},
            '{1'b1, 32'h00400008, 16'h0002, 1'b1, 1'b0, 1'b0,  1'b1, 32'h00400008, 16'h0002, 2'd1, 1'b1, 2'd0},
            '{1'b1, 32'h0040000C, 16'h0003, 1'b1, 1'b0, 1'b0,  1'b1, 32'h0040000C, 16'h0003, 2'd1, 1'b1, 2'd0},
            '{1'b1, 32'h00400010, 16'h0004, 1'b1, 1'b0, 1'b0,  1'b1, 32'h00400010, 16'h0004, 2'd1, 1'b1, 2'd0},
            '{1'b0, 32'h0,        16'h0,    1'b1, 1'b0, 1'b0,  1'b0, 32'h00400010, B,        2'd0, 1'b1, 2'd0},
            '{1'b1, 32'h11,       16'h0011, 1'b0, 1'b0, 1'b0,  1'b1, 32'h11,       16'h0011, 2'd1, 1'b1, 2'd0},
            '{1'b1, 32'h22,       16'h0022, 1'b0, 1'b0, 1'b0,  1'b1, 32'h11,       16'h0011, 2'd2, 1'b0, 2'd0},
            '{1'b1, 32'h99,       16'h0099, 1'b0, 1'b0, 1'b0,  1'b1, 32'h11,       16'h0011, 2'd2, 1'b0, 2'd0},
            '{1'b0, 32'h0,        16'h0,    1'b1, 1'b0, 1'b0,  1'b1, 32'h22,       16'h0022, 2'd1, 1'b1, 2'd0},
            '{1'b0, 32'h0,        16'h0,    1'b1, 1'b0, 1'b0,  1'b0, 32'h22,       B,        2'd0, 1'b1, 2'd0},
            '{1'b1, 32'h33,       16'h0033, 1'b1, 1'b0, 1'b0,  1'b1, 32'h33,       16'h0033, 2'd1, 1'b1, 2'd0},
            '{1'b1, 32'h44,       16'h0044, 1'b1, 1'b1, 1'b0,  1'b1, 32'h33,       16'h0033, 2'd2, 1'b0, 2'd0},
            '{1'b0, 32'h0,        16'h0,    1'b1, 1'b1, 1'b0,  1'b1, 32'h33,       16'h0033, 2'd2, 1'b0, 2'd0},
            '{1'b0, 32'h0,        16'h0,    1'b0, 1'b0, 1'b1,  1'b0, 32'h33,       B,        2'd0, 1'b1, 2'd2},
            '{1'b1, 32'h55,       16'h0055, 1'b0, 1'b0, 1'b0,  1'b1, 32'h55,       16'h0055, 2'd1, 1'b1, 2'd2},
            '{1'b1, 32'h66,       16'h0066, 1'b1, 1'b1, 1'b1,  1'b0, 32'h55,       B,        2'd0, 1'b1, 2'd3}
        };

        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'(B));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].stl, vecs[i].fl);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_data", i), out_data, vecs[i].ed);
            chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ec));
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vecs[i].eocc));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
            chk($sformatf("v%0d_cnt", i), 32'(flush_cnt), 32'(vecs[i].ecnt));
        end

        // flush alongside an emit: the emitted entry is not counted, an accepted one is
        do_reset();
        drive(1'b1, 32'hA1, 16'h00A1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("fe_valid", 32'(out_valid), 32'd0);
        chk("fe_cnt", 32'(flush_cnt), 32'd0);
        drive(1'b1, 32'hA2, 16'h00A2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hA3, 16'h00A3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("fea_valid", 32'(out_valid), 32'd0);
        chk("fea_ctrl", 32'(out_ctrl), 32'(B));
        chk("fea_cnt", 32'(flush_cnt), 32'd1);

        // saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i), 16'(i), 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            tick();
            chk($sformatf("sat%0d_cnt", i), 32'(flush_cnt), (i < 2) ? 32'(i + 1) : 32'd3);
        end

        // asynchronous reset while FULL, checked before any further clock edge
        drive(1'b1, 32'hC1, 16'h00C1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC2, 16'h00C2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("full_occ", 32'(occupancy), 32'd2);
        chk("full_cnt", 32'(flush_cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ctrl", 32'(out_ctrl), 32'(B));
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_cnt", 32'(flush_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_data", out_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
